// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: latch at start, 32 CALC cycles,
// then a single-cycle register-file write request in DONE.
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int RAW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [RAW-1:0]  rd_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            w_en,
  output logic [RAW-1:0]  rd,
  output logic [XLEN-1:0] x_rd
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] opnd;
  } req_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  req_t            req_q;
  // mul: {partial hi, multiplier shifting out low}; div: low half is the dividend/quotient shifter
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]   rem;

  logic            last;
  logic [XLEN:0]   msum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] result;

  assign last = (cnt == CW'(XLEN-1));
  assign busy = (state != IDLE);
  assign w_en = (state == DONE);

  always_comb begin
    msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, req_q.opnd} : '0);
    mul_nxt = {msum, acc[XLEN-1:1]};
    // Borrow out of the widened trial subtract decides the quotient bit
    diff    = {rem, acc[XLEN-1]} - {2'b00, req_q.opnd};
    ge      = ~diff[XLEN+1];
    rem_nxt = ge ? diff[XLEN:0] : {rem[XLEN-1:0], acc[XLEN-1]};
    quo_nxt = {acc[XLEN-2:0], ge};
    case (req_q.op)
      2'b00:   result = mul_nxt[XLEN-1:0];
      2'b01:   result = mul_nxt[2*XLEN-1:XLEN];
      2'b10:   result = quo_nxt;
      default: result = rem_nxt[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      req_q <= '0;
      acc   <= '0;
      rem   <= '0;
      rd    <= '0;
      x_rd  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          req_q.op   <= op;
          req_q.rd   <= rd_in;
          req_q.opnd <= op[1] ? b : a;
          acc        <= {{XLEN{1'b0}}, (op[1] ? a : b)};
          rem        <= '0;
          cnt        <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (req_q.op[1]) begin
            acc <= {acc[2*XLEN-1:XLEN], quo_nxt};
            rem <= rem_nxt;
          end else begin
            acc <= mul_nxt;
          end
          if (last) begin
            x_rd <= result;
            rd   <= req_q.rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
